// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM encoding, counter
// width, alignment mask and the access error check.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    localparam int unsigned CNT_W      = 4;
    localparam logic [2:0]  ALIGN_MASK = 3'b111;

    // A doubleword access is bad when it is not 8-byte aligned or when its
    // word number lies beyond the end of the array.
    function automatic logic access_err(input logic [63:0] addr, input logic [63:0] depth);
        return ((addr[2:0] & ALIGN_MASK) != 3'b000) || ({3'b000, addr[63:3]} >= depth);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous doubleword array with a registered read port.
// The read register doubles as the response data register: it loads on a
// good load, clears on stores, errors and the response handshake.
module dmem_array #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              re,
    input  logic              clr,
    input  logic [ADDR_W-1:0] idx,
    input  logic [63:0]       wdata,
    output logic [63:0]       rdata
);

    logic [63:0] mem_r [DEPTH_WORDS];
    logic [63:0] rdata_r;

    // Storage write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[idx] <= wdata;
        end
    end

    // Registered read data, cleared whenever no load data should be shown.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rdata_r <= 64'h0;
        end else if (clr) begin
            rdata_r <= 64'h0;
        end else if (re) begin
            rdata_r <= mem_r[idx];
        end else begin
            rdata_r <= rdata_r;
        end
    end

    assign rdata = rdata_r;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one doubleword load/store, waits a fixed
// number of cycles, accesses the array and holds the response until taken.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_rdata,
    output logic        resp_err,
    output logic        busy
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    dmem_state_e      state_r;
    logic [CNT_W-1:0] cnt_r;
    logic             write_r;
    logic [63:0]      addr_r;
    logic [63:0]      wdata_r;
    logic             err_r;

    logic             access_s;
    logic             err_s;
    logic             we_s;
    logic             re_s;
    logic             clr_s;
    logic [AW-1:0]    idx_s;

    // Access strobes, all derived from latched request fields and state.
    always_comb begin
        access_s = (state_r == WAIT) && (cnt_r == 4'd0);
        err_s    = access_err(addr_r, 64'(DEPTH_WORDS));
        idx_s    = addr_r[3+AW-1:3];
        we_s     = access_s && write_r && !err_s;
        re_s     = access_s && !write_r && !err_s;
        clr_s    = (access_s && (write_r || err_s)) ||
                   ((state_r == RESP) && resp_ready);
    end

    // Request FSM, wait counter, request latches and error flag.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            write_r <= 1'b0;
            addr_r  <= 64'h0;
            wdata_r <= 64'h0;
            err_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (req_valid) begin
                        write_r <= req_write;
                        addr_r  <= req_addr;
                        wdata_r <= req_wdata;
                        cnt_r   <= 4'(WAIT_CYCLES);
                        state_r <= WAIT;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt_r != 4'd0) begin
                        cnt_r <= cnt_r - 4'd1;
                    end else begin
                        err_r   <= err_s;
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        err_r   <= 1'b0;
                        state_r <= IDLE;
                    end else begin
                        state_r <= RESP;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= 4'd0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW)
    ) u_array (
        .clk   (clk),
        .reset (reset),
        .we    (we_s),
        .re    (re_s),
        .clr   (clr_s),
        .idx   (idx_s),
        .wdata (wdata_r),
        .rdata (resp_rdata)
    );

    assign req_ready  = (state_r == IDLE);
    assign resp_valid = (state_r == RESP);
    assign busy       = (state_r != IDLE);
    assign resp_err   = err_r;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder serving the pipeline's MEM stage over a valid/ready request/response handshake. It accepts one 64-bit doubleword load or store at a time, applies a configurable number of wait states, performs the access on an internal synchronous array, and returns read data or a write acknowledge. Misaligned and out-of-range accesses return an error response and leave the array unchanged. It replaces the zero-latency data memory so the pipeline can be exercised against realistic memory latency.

## Interface

Parameters:
- DEPTH_WORDS, 1024: number of 64-bit words; power of two, ≥ 2.
- WAIT_CYCLES, 2: extra cycles between accept and access; 0..15.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state except array contents.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept; high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_addr  in  64  byte address.
- req_wdata  in  64  store data.
- resp_valid  out  1  response present.
- resp_ready  in  1  pipeline takes response.
- resp_rdata  out  64  load data; 0 for stores and errors.
- resp_err  out  1  misaligned or out-of-range access.
- busy  out  1  state ≠ IDLE.

## Operation

- States: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On a cycle with req_valid=1, latch write, addr, wdata; load cnt=WAIT_CYCLES; go to WAIT.
- WAIT: cnt≠0 → decrement. cnt=0 → perform access at this edge; go to RESP.
- Access:
  - err = (addr[2:0]≠0) or (addr[63:3] ≥ DEPTH_WORDS).
  - Word index = addr[3+log2(DEPTH_WORDS)-1:3].
  - Store without err: write array[index]=wdata; resp_rdata=0.
  - Load without err: register array[index] into resp_rdata.
  - err: no write; resp_rdata=0; resp_err=1.
- RESP: resp_valid=1; resp_rdata and resp_err are held stable. On a cycle with resp_ready=1, go to IDLE and clear resp_valid, resp_err and resp_rdata.
- Inputs are sampled only at the accept edge; req_* changes during WAIT/RESP are ignored.
- Reset asserted in any state: immediately go to IDLE, cnt=0, outputs to reset values. An in-flight store that has not reached its access edge is dropped. An already written word remains written.
- Array contents are not reset and read X until written.

## Timing

- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
- Latency: resp_valid rises WAIT_CYCLES+1 edges after the accept edge. With WAIT_CYCLES=0 this is 1 cycle.
- Store becomes visible to a subsequent load from the access edge onward.
- Throughput: at most one request per WAIT_CYCLES+3 cycles (accept, waits, access, handshake), with resp_ready tied high.
- No combinational path from req_valid or resp_ready to any output. req_ready and resp_valid are state decodes only.
- resp_ready held low: RESP is held indefinitely, outputs stable, req_ready=0.
- req_valid=1 while not IDLE: the request is not accepted and stays pending on the initiator side.

## Structure

- Shared package dmem_pkg:
  - state enum (IDLE=2'd0, WAIT=2'd1, RESP=2'd2);
  - cnt width constant (4);
  - alignment mask constant 3'b111.
- Sub-module dmem_array: single-port synchronous array (DEPTH_WORDS×64), write enable plus registered read. It holds the only memory inference; the top holds the FSM, counter, latches and error check.

## Test plan

- Reset, then store req_addr=0x10, wdata=0xDEADBEEF_CAFEF00D, WAIT_CYCLES=2 → resp_valid 3 cycles after accept, resp_err=0, resp_rdata=0. Then load 0x10 → resp_rdata=0xDEADBEEF_CAFEF00D.
- Load req_addr=0x13 → resp_err=1, resp_rdata=0. Store to 0x2000 with DEPTH_WORDS=1024 → resp_err=1; a subsequent load of word 0 is unchanged.
- resp_ready held low 10 cycles in RESP → resp_valid, resp_rdata, resp_err stable; req_ready=0; a new req_valid is not accepted until 1 cycle after resp_ready=1.
- WAIT_CYCLES=0, back-to-back stores to 0x0 and 0x8, then loads with resp_ready=1 → each response 1 cycle after accept; 3-cycle spacing between accepts; data correct.
- Assert reset during WAIT of a store to 0x18 → outputs at reset values immediately, busy=0. A later load of 0x18 returns the prior contents.
- Change req_addr/req_wdata during WAIT → the response reflects the values latched at accept.
